// File: rtl/elev_call_arbiter.sv
// Elevator call arbiter: debounces raw call buttons, latches pending calls and
// presents one nearest-first call at a time to the elevator controller.
//
// Ports:
//   i_clk        system clock, all logic on rising edge
//   i_rst        synchronous active-high reset
//   i_btn_raw    raw asynchronous button levels, 1 = pressed
//   i_floor_sel  current floor from the controller (0 = floor one)
//   i_door       controller door status, 1 = open
//   o_floor_btn  registered one-hot call to the controller, 0 = no call
//   o_pending    latched outstanding calls, bit i = floor i+1
//   o_busy       1 while a call is presented on o_floor_btn
module elev_call_arbiter #(
    parameter int NUM_FLOORS      = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_FLOORS-1:0]         i_btn_raw,
    input  logic [$clog2(NUM_FLOORS)-1:0] i_floor_sel,
    input  logic                          i_door,
    output logic [NUM_FLOORS-1:0]         o_floor_btn,
    output logic [NUM_FLOORS-1:0]         o_pending,
    output logic                          o_busy
);

    localparam int SW = $clog2(NUM_FLOORS);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_SERVE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NUM_FLOORS-1:0] r_sync1;
    logic [NUM_FLOORS-1:0] r_sync2;
    logic [NUM_FLOORS-1:0] r_db;
    logic [CW-1:0]         r_cnt [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] r_pending;
    logic [SW-1:0]         r_target;
    logic                  r_dir_up;
    logic [NUM_FLOORS-1:0] r_floor_btn;
    logic                  r_busy;

    logic [NUM_FLOORS-1:0] w_accept;
    logic [NUM_FLOORS-1:0] w_serve;
    logic [NUM_FLOORS-1:0] w_cand;
    logic [NUM_FLOORS-1:0] w_onehot;
    logic [NUM_FLOORS-1:0] w_btn_nxt;
    logic [SW-1:0]         w_sel_tgt;
    logic                  w_sel_valid;
    logic                  w_load;
    int                    w_dist;
    int                    w_best;

    // An accept is the debounced level rising; the toggle and the accept
    // happen on the same edge so the raw-to-pending latency stays minimal.
    always_comb begin
        w_accept = '0;
        w_serve  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            w_accept[i] = (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) & ~r_db[i];
            w_serve[i]  = i_door & (i_floor_sel == SW'(i));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_FLOORS; i++) begin
                if (r_cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Service clears win over a same-cycle accept on the same bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_accept) & ~w_serve;
        end
    end

    // Nearest-first selection. Ties can only pair one floor below with one
    // above; scanning upward, "<=" lets the upper one win when heading up.
    // Calls being served right now are excluded from the candidates.
    always_comb begin
        w_cand      = r_pending & ~w_serve;
        w_sel_valid = 1'b0;
        w_sel_tgt   = '0;
        w_best      = NUM_FLOORS;
        w_dist      = 0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(i_floor_sel)) begin
                w_dist = i - int'(i_floor_sel);
            end else begin
                w_dist = int'(i_floor_sel) - i;
            end
            if (w_cand[i] &&
                (w_dist < w_best || (w_dist == w_best && r_dir_up))) begin
                w_best      = w_dist;
                w_sel_tgt   = SW'(i);
                w_sel_valid = 1'b1;
            end
        end
    end

    assign w_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << r_target;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_btn_nxt   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_sel_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_serve[r_target]) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_btn_nxt = w_onehot;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_target    <= '0;
            r_dir_up    <= 1'b1;
            r_floor_btn <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_floor_btn <= w_btn_nxt;
            r_busy      <= |w_btn_nxt;
            if (w_load) begin
                r_target <= w_sel_tgt;
                if (w_sel_tgt > i_floor_sel) begin
                    r_dir_up <= 1'b1;
                end else if (w_sel_tgt < i_floor_sel) begin
                    r_dir_up <= 1'b0;
                end
            end
        end
    end

    assign o_floor_btn = r_floor_btn;
    assign o_pending   = r_pending;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_elev_call_arbiter.sv
// Directed bench for elev_call_arbiter: expectations are queued with a due
// cycle when stimulus is driven and compared when that cycle is reached.
module tb_elev_call_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [1:0] floor_sel;
    logic       door;
    logic [3:0] floor_btn;
    logic [3:0] pending;
    logic       busy;

    typedef struct {
        int         at;
        logic [3:0] fb;
        logic [3:0] pd;
        logic       bz;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    elev_call_arbiter #(
        .NUM_FLOORS      (4),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_raw   (btn_raw),
        .i_floor_sel (floor_sel),
        .i_door      (door),
        .o_floor_btn (floor_btn),
        .o_pending   (pending),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_at(input int dly, input logic [3:0] fb,
                             input logic [3:0] pd, input logic bz,
                             input string tag);
        exp_t e;
        e.at  = cyc + dly;
        e.fb  = fb;
        e.pd  = pd;
        e.bz  = bz;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [8:0] obs;
        logic [8:0] req;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e   = sb.pop_front();
            obs = {floor_btn, pending, busy};
            req = {e.fb, e.pd, e.bz};
            checks++;
            assert (obs === req) else begin
                errors++;
                $error("FAIL %s cyc=%0d got fb=%b pd=%b busy=%b exp fb=%b pd=%b busy=%b",
                       e.tag, cyc, floor_btn, pending, busy, e.fb, e.pd, e.bz);
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            drain();
        end
    endtask

    initial begin
        rst       = 1'b1;
        btn_raw   = 4'b0000;
        floor_sel = 2'd0;
        door      = 1'b0;
        step(2);
        expect_at(0, 4'b0000, 4'b0000, 1'b0, "reset");
        drain();
        rst = 1'b0;

        // Bouncing button never settles long enough to be accepted.
        for (int k = 0; k < 12; k++) begin
            btn_raw = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            expect_at(3, 4'b0000, 4'b0000, 1'b0, "bounce");
            step(5);
        end
        btn_raw = 4'b0000;
        expect_at(25, 4'b0000, 4'b0000, 1'b0, "bounce_end");
        step(25);

        // Clean press on floor 3: latency to pending and to floor_btn.
        door    = 1'b1;
        btn_raw = 4'b0100;
        expect_at(18, 4'b0000, 4'b0000, 1'b0, "t1_pre");
        expect_at(19, 4'b0000, 4'b0100, 1'b0, "t1_pend");
        expect_at(20, 4'b0000, 4'b0100, 1'b0, "t1_lat");
        expect_at(21, 4'b0100, 4'b0100, 1'b1, "t1_drive");
        step(20);
        btn_raw = 4'b0000;
        step(1);

        // New press while serving does not retarget.
        btn_raw = 4'b0010;
        expect_at(19, 4'b0100, 4'b0110, 1'b1, "t3_hold");
        step(19);
        btn_raw   = 4'b0000;
        floor_sel = 2'd2;
        door      = 1'b1;
        expect_at(1, 4'b0000, 4'b0010, 1'b0, "t3_exit");
        expect_at(2, 4'b0000, 4'b0010, 1'b0, "t3_gap");
        expect_at(3, 4'b0010, 4'b0010, 1'b1, "t3_next");
        step(3);
        floor_sel = 2'd1;
        expect_at(1, 4'b0000, 4'b0000, 1'b0, "t3_done");
        step(1);

        // Press at the open floor is ignored.
        floor_sel = 2'd3;
        door      = 1'b1;
        btn_raw   = 4'b1000;
        expect_at(19, 4'b0000, 4'b0000, 1'b0, "t5_pend");
        expect_at(22, 4'b0000, 4'b0000, 1'b0, "t5_idle");
        step(22);
        btn_raw = 4'b0000;
        step(22);

        // Distance tie resolved by direction, first UP then DOWN.
        rst = 1'b1;
        step(1);
        expect_at(0, 4'b0000, 4'b0000, 1'b0, "t4_rst");
        drain();
        rst       = 1'b0;
        floor_sel = 2'd1;
        door      = 1'b0;
        btn_raw   = 4'b0101;
        expect_at(19, 4'b0000, 4'b0101, 1'b0, "t4_pend");
        expect_at(21, 4'b0100, 4'b0101, 1'b1, "t4_up");
        step(21);
        btn_raw   = 4'b0000;
        floor_sel = 2'd2;
        door      = 1'b1;
        expect_at(1, 4'b0000, 4'b0001, 1'b0, "t4_srv2");
        step(1);
        door = 1'b0;
        expect_at(2, 4'b0001, 4'b0001, 1'b1, "t4_far");
        step(2);
        floor_sel = 2'd0;
        door      = 1'b1;
        expect_at(1, 4'b0000, 4'b0000, 1'b0, "t4_srv0");
        step(1);
        floor_sel = 2'd1;
        door      = 1'b0;
        step(20);
        btn_raw = 4'b0101;
        expect_at(19, 4'b0000, 4'b0101, 1'b0, "t4_pend2");
        expect_at(21, 4'b0001, 4'b0101, 1'b1, "t4_down");
        step(21);
        btn_raw = 4'b0000;
        step(20);

        // Multi-press, tie resolves UP after reset, then reset while busy.
        rst = 1'b1;
        step(1);
        rst       = 1'b0;
        floor_sel = 2'd2;
        door      = 1'b0;
        btn_raw   = 4'b1011;
        expect_at(19, 4'b0000, 4'b1011, 1'b0, "t6_pend");
        expect_at(21, 4'b1000, 4'b1011, 1'b1, "t6_tie_up");
        step(21);
        rst     = 1'b1;
        btn_raw = 4'b0000;
        expect_at(1, 4'b0000, 4'b0000, 1'b0, "t6_rst");
        step(1);
        rst = 1'b0;
        expect_at(25, 4'b0000, 4'b0000, 1'b0, "t6_quiet");
        step(25);

        checks++;
        assert (sb.size() === 0) else begin
            errors++;
            $error("FAIL sb_empty got %0d entries left exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
